// File: rtl/deconcatenador_out_if.sv
// Handshake bundle for the mining block receiver: upstream block bus
// and downstream split entry/nonce bus.
interface deconcatenador_out_if #(
  parameter int CNT_W = 16
);
  logic                   selector;
  logic                   block_valid;
  logic                   block_ready;
  logic [7:0][15:0]       block_in;
  logic                   entry_valid;
  logic                   entry_ready;
  logic [7:0][11:0]       entry_12;
  logic [7:0][3:0]        nonce;
  logic                   dropped;
  logic [CNT_W-1:0]       block_count;

  modport slave (
    input  selector,
    input  block_valid,
    input  block_in,
    input  entry_ready,
    output block_ready,
    output entry_valid,
    output entry_12,
    output nonce,
    output dropped,
    output block_count
  );

  modport master (
    output selector,
    output block_valid,
    output block_in,
    output entry_ready,
    input  block_ready,
    input  entry_valid,
    input  entry_12,
    input  nonce,
    input  dropped,
    input  block_count
  );
endinterface

// File: rtl/deconcatenador_out.sv
// Receive-side deconcatenator: filters filler blocks, buffers DEPTH
// blocks and splits the head into entry_12 / nonce fields.
module deconcatenador_out #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input logic                 clk,
  input logic                 reset,
  deconcatenador_out_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

  logic [127:0]     r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_occ;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dropped;

  logic             w_full;
  logic             w_empty;
  logic             w_acc;
  logic             w_filler;
  logic             w_push;
  logic             w_pop;
  logic [127:0]     w_head;

  assign w_full   = (r_occ == OCC_FULL);
  assign w_empty  = (r_occ == '0);
  assign w_acc    = bus.block_valid & ~w_full;
  assign w_filler = ~bus.selector | (bus.block_in == '0);
  assign w_push   = w_acc & ~w_filler;
  assign w_pop    = ~w_empty & bus.entry_ready;

  // Empty buffer forces the split fields to zero.
  assign w_head = w_empty ? '0 : r_mem[r_rd];

  assign bus.block_ready = ~w_full;
  assign bus.entry_valid = ~w_empty;
  assign bus.entry_12    = w_head[127:32];
  assign bus.nonce       = w_head[31:0];
  assign bus.dropped     = r_dropped;
  assign bus.block_count = r_cnt;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= bus.block_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr      <= '0;
      r_rd      <= '0;
      r_occ     <= '0;
      r_cnt     <= '0;
      r_dropped <= 1'b0;
    end else begin
      r_dropped <= w_acc & w_filler;
      if (w_push) begin
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd  <= r_rd + 1'b1;
        r_cnt <= r_cnt + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: tb/tb_deconcatenador_out.sv
// Bench for deconcatenador_out: queue model checked every cycle plus
// directed literal expectations.
module tb_deconcatenador_out;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic chk_en = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  deconcatenador_out_if #(.CNT_W(16)) bus();

  deconcatenador_out #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [127:0] q[$];
  logic [15:0]  m_cnt = '0;
  bit           m_drop = 1'b0;
  bit           m_acc;
  bit           m_pop;
  logic [127:0] m_head;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a bounded queue of accepted, non-filler blocks.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_cnt  = '0;
      m_drop = 1'b0;
    end else begin
      m_acc  = bus.block_valid && (q.size() < DEPTH);
      m_pop  = (q.size() != 0) && bus.entry_ready;
      m_drop = m_acc && (!bus.selector || bus.block_in == '0);
      if (m_pop) begin
        void'(q.pop_front());
        m_cnt = m_cnt + 16'd1;
      end
      if (m_acc && !m_drop) q.push_back(bus.block_in);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      m_head = (q.size() != 0) ? q[0] : '0;
      chk("entry_valid", 128'(bus.entry_valid), 128'(q.size() != 0));
      chk("entry_12", 128'(bus.entry_12), 128'(m_head[127:32]));
      chk("nonce", 128'(bus.nonce), 128'(m_head[31:0]));
      chk("block_ready", 128'(bus.block_ready), 128'(q.size() < DEPTH));
      chk("dropped", 128'(bus.dropped), 128'(m_drop));
      chk("block_count", 128'(bus.block_count), 128'(m_cnt));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(logic [127:0] d, logic sel);
    int  n;
    bit  w;
    n = 0;
    bus.block_valid = 1'b1;
    bus.selector    = sel;
    bus.block_in    = d;
    do begin
      w = bus.block_ready;
      step();
      n++;
    end while (!w && n < 20);
    if (!w) begin
      n_cmp++;
      n_bad++;
      $display("FAIL push_timeout: got stalled want accepted");
    end
    bus.block_valid = 1'b0;
  endtask

  task automatic stream(int n, int base);
    bus.block_valid = 1'b1;
    bus.selector    = 1'b1;
    bus.entry_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.block_in = {16'hBEEF, 80'(base + i), 32'(base + i)};
      step();
    end
    bus.block_valid = 1'b0;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  logic [127:0] ba, bb, bc;

  initial begin
    #400000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.selector    = 1'b0;
    bus.block_valid = 1'b0;
    bus.block_in    = '0;
    bus.entry_ready = 1'b0;
    #1 rst = 1'b1;
    #1 chk_en = 1'b1;
    step();
    chk("rst_ready", 128'(bus.block_ready), 128'd1);
    chk("rst_valid", 128'(bus.entry_valid), 128'd0);
    rst = 1'b0;
    step();

    // single block, 1-cycle latency
    bus.entry_ready = 1'b1;
    bus.block_valid = 1'b1;
    bus.selector    = 1'b1;
    bus.block_in    = 128'h0123456789ABCDEF0011223344556677;
    step();
    bus.block_valid = 1'b0;
    chk("t1_valid", 128'(bus.entry_valid), 128'd1);
    chk("t1_e12", 128'(bus.entry_12), 128'h0123456789ABCDEF00112233);
    chk("t1_nonce", 128'(bus.nonce), 128'h44556677);
    step();
    chk("t1_count", 128'(bus.block_count), 128'd1);
    chk("t1_e12_zero", 128'(bus.entry_12), 128'd0);

    // filler drops
    bus.block_valid = 1'b1;
    bus.selector    = 1'b0;
    bus.block_in    = 128'hDEAD;
    step();
    chk("t2_drop_sel", 128'(bus.dropped), 128'd1);
    bus.selector = 1'b1;
    bus.block_in = '0;
    step();
    chk("t2_drop_zero", 128'(bus.dropped), 128'd1);
    bus.block_valid = 1'b0;
    step();
    chk("t2_drop_end", 128'(bus.dropped), 128'd0);
    chk("t2_valid", 128'(bus.entry_valid), 128'd0);
    chk("t2_count", 128'(bus.block_count), 128'd1);

    // backpressure with DEPTH=2
    ba = {8{16'hA1A2}};
    bb = {8{16'hB1B2}};
    bc = {8{16'hC1C2}};
    bus.entry_ready = 1'b0;
    push(ba, 1'b1);
    push(bb, 1'b1);
    fork
      push(bc, 1'b1);
      begin
        step();
        step();
        chk("t3_full", 128'(bus.block_ready), 128'd0);
        chk("t3_headA", 128'(bus.entry_12), 128'(ba[127:32]));
        bus.entry_ready = 1'b1;
      end
    join
    chk("t3_headC", 128'(bus.entry_12), 128'(bc[127:32]));
    chk("t3_cnt3", 128'(bus.block_count), 128'd3);
    step();
    chk("t3_count", 128'(bus.block_count), 128'd4);
    chk("t3_empty", 128'(bus.entry_valid), 128'd0);

    // streaming and counter wrap
    do_reset();
    chk("t4_rst_cnt", 128'(bus.block_count), 128'd0);
    stream(10, 1);
    chk("t4_count10", 128'(bus.block_count), 128'd10);
    stream(65525, 100);
    chk("t5_ffff", 128'(bus.block_count), 128'hFFFF);
    stream(1, 7);
    chk("t5_wrap", 128'(bus.block_count), 128'd0);

    // asynchronous reset mid-stream
    bus.entry_ready = 1'b0;
    push(128'h1, 1'b1);
    push(128'h2, 1'b1);
    chk("t6_full", 128'(bus.block_ready), 128'd0);
    #3 rst = 1'b1;
    #1;
    chk("t6_valid", 128'(bus.entry_valid), 128'd0);
    chk("t6_e12", 128'(bus.entry_12), 128'd0);
    chk("t6_nonce", 128'(bus.nonce), 128'd0);
    chk("t6_cnt", 128'(bus.block_count), 128'd0);
    chk("t6_ready", 128'(bus.block_ready), 128'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    bus.entry_ready = 1'b1;
    repeat (3) step();
    chk("t6_stale", 128'(bus.entry_valid), 128'd0);
    chk("t6_cnt_after", 128'(bus.block_count), 128'd0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
